skeeball_hit_detector: RTL and testbench

//  Front end of the skeeball lane. Turns raw hole-sensor switches and the start button into the game-control
//  and hit strobes that drive the BCD score accumulator.

---
 rtl/skeeball_pkg.sv | 35 +++
 rtl/skeeball_hit_detector_if.sv | 24 ++
 rtl/skeeball_debounce.sv | 49 ++++
 rtl/skeeball_hit_detector.sv | 157 +++++++++++++++
 tb/tb_skeeball_hit_detector.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/skeeball_pkg.sv
// Shared types and constants for the skeeball lane front end.
package skeeball_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PLAY,
      HIT,
      HOLDOFF,
      OVER
   } state_t;

   localparam int HOLE_0     = 0;
   localparam int HOLE_10    = 1;
   localparam int HOLE_20    = 2;
   localparam int HOLE_30    = 3;
   localparam int HOLE_40    = 4;
   localparam int HOLE_50    = 5;
   localparam int HOLE_100   = 6;
   localparam int NUM_HOLES  = 7;
   localparam int HIT_CYCLES = 3;

   // Ascending scan so the highest-value hole overwrites any lower one.
   function automatic logic [NUM_HOLES-1:0] pick_highest(input logic [NUM_HOLES-1:0] ev);
      logic [NUM_HOLES-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_HOLES; i++) begin
         if (ev[i]) begin
            oh    = '0;
            oh[i] = 1'b1;
         end
      end
      return oh;
   endfunction

endpackage

// File: rtl/skeeball_hit_detector_if.sv
// Lane bundle: raw switches in, game-control and score strobes out.
interface skeeball_hit_detector_if;
   import skeeball_pkg::*;

   logic [NUM_HOLES-1:0] sensor_raw;
   logic                 start_raw;
   logic                 play_state;
   logic                 game_over;
   logic [3:0]           balls_left;
   logic [NUM_HOLES-1:0] hit;
   logic                 ball_clk;
   logic [NUM_HOLES-1:0] fault;

   modport master (
      output sensor_raw, start_raw,
      input  play_state, game_over, balls_left, hit, ball_clk, fault
   );

   modport slave (
      input  sensor_raw, start_raw,
      output play_state, game_over, balls_left, hit, ball_clk, fault
   );

endinterface

// File: rtl/skeeball_debounce.sv
// One input bit: two-flop synchroniser, consecutive-sample debouncer and a registered rising-edge pulse.
module skeeball_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_rise;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         // Any sample agreeing with the committed level restarts the run.
         if (r_sync2 != r_level) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_level <= r_sync2;
               r_rise  <= r_sync2;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;

endmodule

// File: rtl/skeeball_hit_detector.sv
// Skeeball lane front end: debounced sensors and start button drive the game sequencer and hit strobes.
// Stuck-sensor detection is compiled in when STUCK_SENSOR_EN is defined.
module skeeball_hit_detector
   import skeeball_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int HOLDOFF_CYCLES  = 64,
   parameter int BALLS_PER_GAME  = 9,
   parameter int STUCK_CYCLES    = 4096
) (
   input  logic                   clk,
   input  logic                   rst_n,
   skeeball_hit_detector_if.slave io_lane
);

   localparam int TMAX = (HOLDOFF_CYCLES > HIT_CYCLES) ? HOLDOFF_CYCLES : HIT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   logic [NUM_HOLES:0]   w_raw;
   logic [NUM_HOLES:0]   w_level;
   logic [NUM_HOLES:0]   w_rise;
   logic [NUM_HOLES-1:0] w_fault;
   logic [NUM_HOLES-1:0] w_event;
   logic                 w_start_ev;
   logic                 w_game_start;
   logic                 w_unused_level;

   state_t               r_state,  w_state_next;
   logic [TW-1:0]        r_tmr,    w_tmr_next;
   logic [3:0]           r_balls,  w_balls_next;
   logic [NUM_HOLES-1:0] r_hit,    w_hit_next;

   // Bit NUM_HOLES carries the start button through the same input path as the holes.
   assign w_raw = {io_lane.start_raw, io_lane.sensor_raw};

   for (genvar gi = 0; gi <= NUM_HOLES; gi++) begin : g_in
      skeeball_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_raw   (w_raw[gi]),
         .o_level (w_level[gi]),
         .o_rise  (w_rise[gi])
      );
   end

`ifdef STUCK_SENSOR_EN
   localparam int SW = $clog2(STUCK_CYCLES + 1);

   for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_stuck
      logic [SW-1:0] r_cnt;
      logic          r_fault;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
         end else begin
            if (!w_level[gi]) begin
               r_cnt <= '0;
            end else if (r_cnt != SW'(STUCK_CYCLES)) begin
               r_cnt <= r_cnt + SW'(1);
            end
            // A new game clears the flag; a sensor still stuck re-flags on the next cycle.
            if (w_game_start) begin
               r_fault <= 1'b0;
            end else if (w_level[gi] && (r_cnt >= SW'(STUCK_CYCLES - 1))) begin
               r_fault <= 1'b1;
            end
         end
      end

      assign w_fault[gi] = r_fault;
   end

   assign w_unused_level = w_level[NUM_HOLES];
`else
   assign w_fault        = '0;
   assign w_unused_level = ^{w_level, w_game_start};
`endif

   assign w_event    = w_rise[NUM_HOLES-1:0] & ~w_fault;
   assign w_start_ev = w_rise[NUM_HOLES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_tmr   <= '0;
         r_balls <= '0;
         r_hit   <= '0;
      end else begin
         r_state <= w_state_next;
         r_tmr   <= w_tmr_next;
         r_balls <= w_balls_next;
         r_hit   <= w_hit_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_tmr_next   = r_tmr;
      w_balls_next = r_balls;
      w_hit_next   = r_hit;
      w_game_start = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start_ev) begin
               w_state_next = PLAY;
               w_balls_next = 4'(BALLS_PER_GAME);
               w_game_start = 1'b1;
            end
         end
         PLAY: begin
            if (|w_event) begin
               w_state_next = HIT;
               w_hit_next   = pick_highest(w_event);
               w_tmr_next   = '0;
            end
         end
         HIT: begin
            if (r_tmr == TW'(HIT_CYCLES - 1)) begin
               w_state_next = HOLDOFF;
               w_tmr_next   = '0;
               if (r_balls != 4'd0) begin
                  w_balls_next = r_balls - 4'd1;
               end
            end else begin
               w_tmr_next = r_tmr + TW'(1);
            end
         end
         HOLDOFF: begin
            if (r_tmr == TW'(HOLDOFF_CYCLES - 1)) begin
               w_state_next = (r_balls == 4'd0) ? OVER : PLAY;
               w_tmr_next   = '0;
            end else begin
               w_tmr_next = r_tmr + TW'(1);
            end
         end
         OVER: begin
            if (w_start_ev) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // ball_clk sits in the middle hit cycle so its falling edge meets a stable hit vector.
   assign io_lane.play_state = (r_state != IDLE);
   assign io_lane.game_over  = (r_state == OVER);
   assign io_lane.balls_left = r_balls;
   assign io_lane.hit        = (r_state == HIT) ? r_hit : '0;
   assign io_lane.ball_clk   = (r_state == HIT) && (r_tmr == TW'(1));
   assign io_lane.fault      = w_fault;

endmodule

// File: tb/tb_skeeball_hit_detector.sv
// Self-checking bench for skeeball_hit_detector: directed scenarios plus random stimulus against a cycle model.
module tb_skeeball_hit_detector;
   import skeeball_pkg::*;

   localparam int DB  = 4;
   localparam int HO  = 8;
   localparam int BPG = 3;
   localparam int SC  = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   chk_en = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   skeeball_hit_detector_if lane();

   skeeball_hit_detector #(
      .DEBOUNCE_CYCLES (DB),
      .HOLDOFF_CYCLES  (HO),
      .BALLS_PER_GAME  (BPG),
      .STUCK_CYCLES    (SC)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .io_lane (lane)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Inputs reach the debouncer two clocks late; a level commits after DB
   // consecutive disagreeing samples. A scored ball occupies 3 hit cycles plus
   // HO hold-off cycles measured from the clock at which it was accepted.
   bit [7:0] m_s1, m_s2, m_lvl, m_rise;
   int       m_run [8];
   int       m_stk [7];
   bit [6:0] m_fault, m_hitv;
   int       m_mode;   // 0 idle, 1 waiting for ball, 2 ball scored/rolling, 3 game over
   int       m_t0, m_balls, m_cyc;

   function automatic bit [6:0] top_hole(input bit [6:0] ev);
      bit [6:0] h;
      h = '0;
      for (int i = 6; i >= 0; i--) begin
         if (ev[i]) begin
            h[i] = 1'b1;
            break;
         end
      end
      return h;
   endfunction

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0;
      m_fault = '0; m_hitv = '0;
      m_mode = 0; m_t0 = 0; m_balls = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      for (int i = 0; i < 7; i++) m_stk[i] = 0;
   endtask

   task automatic model_step();
      bit [6:0] ev;
      bit [7:0] new_rise;
      int       k;
`ifdef STUCK_SENSOR_EN
      bit       game_start;
      game_start = 1'b0;
`endif
      m_cyc++;
      ev = m_rise[6:0];
`ifdef STUCK_SENSOR_EN
      ev = ev & ~m_fault;
`endif
      case (m_mode)
         0: if (m_rise[7]) begin
               m_mode  = 1;
               m_balls = BPG;
`ifdef STUCK_SENSOR_EN
               game_start = 1'b1;
`endif
            end
         1: if (ev != 0) begin
               m_mode = 2;
               m_t0   = m_cyc;
               m_hitv = top_hole(ev);
            end
         2: begin
               k = m_cyc - m_t0;
               if (k == 3 && m_balls > 0) m_balls--;
               if (k == 3 + HO) m_mode = (m_balls == 0) ? 3 : 1;
            end
         3: if (m_rise[7]) m_mode = 0;
         default: m_mode = 0;
      endcase
`ifdef STUCK_SENSOR_EN
      for (int i = 0; i < 7; i++) begin
         m_stk[i] = m_lvl[i] ? ((m_stk[i] < SC) ? m_stk[i] + 1 : SC) : 0;
         if (game_start) m_fault[i] = 1'b0;
         else if (m_stk[i] == SC) m_fault[i] = 1'b1;
      end
`endif
      new_rise = '0;
      for (int b = 0; b < 8; b++) begin
         if (m_s2[b] != m_lvl[b]) begin
            m_run[b]++;
            if (m_run[b] == DB) begin
               m_lvl[b]    = m_s2[b];
               m_run[b]    = 0;
               new_rise[b] = m_s2[b];
            end
         end else begin
            m_run[b] = 0;
         end
      end
      m_rise = new_rise;
      m_s2   = m_s1;
      m_s1   = {lane.start_raw, lane.sensor_raw};
   endtask

   initial begin
      m_cyc = 0;
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Compare every output against the model on every falling edge.
   initial begin : compare_proc
      int       k;
      bit [6:0] e_hit;
      bit       e_bclk;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            k      = m_cyc - m_t0;
            e_hit  = (m_mode == 2 && k < 3) ? m_hitv : 7'd0;
            e_bclk = (m_mode == 2 && k == 1);
            check("play_state", 32'(lane.play_state), 32'(m_mode != 0));
            check("game_over",  32'(lane.game_over),  32'(m_mode == 3));
            check("balls_left", 32'(lane.balls_left), 32'(m_balls));
            check("hit",        32'(lane.hit),        32'(e_hit));
            check("ball_clk",   32'(lane.ball_clk),   32'(e_bclk));
            check("fault",      32'(lane.fault),      32'(m_fault));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_in(input logic [6:0] s, input logic st);
      @(posedge clk);
      #1;
      lane.sensor_raw = s;
      lane.start_raw  = st;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic press_start();
      set_in(7'd0, 1'b1);
      wait_cyc(7);
      set_in(7'd0, 1'b0);
      wait_cyc(12);
   endtask

   task automatic pulse(input logic [6:0] s, input int hold);
      set_in(s, 1'b0);
      wait_cyc(hold);
      set_in(7'd0, 1'b0);
   endtask

   initial begin
      int guard;
      lane.sensor_raw = '0;
      lane.start_raw  = 1'b0;
      rst_n = 1'b0;
      wait_cyc(2);
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_play",  32'(lane.play_state), 32'd0);
      check("reset_balls", 32'(lane.balls_left), 32'd0);
      check("reset_hit",   32'(lane.hit),        32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_cyc(3);

      // 1: start held 10 cycles
      set_in(7'd0, 1'b1);
      wait_cyc(9);
      set_in(7'd0, 1'b0);
      @(negedge clk);
      check("t1_play",  32'(lane.play_state), 32'd1);
      check("t1_balls", 32'(lane.balls_left), 32'd3);
      check("t1_hit",   32'(lane.hit),        32'd0);
      check("t1_bclk",  32'(lane.ball_clk),   32'd0);
      wait_cyc(5);

      // 2: 30-point hole, latency 3+DB = 7 clocks
      set_in(7'b0001000, 1'b0);
      wait_cyc(6);
      @(negedge clk);
      check("t2_early_hit", 32'(lane.hit), 32'd0);
      @(negedge clk);
      check("t2_h0_hit",  32'(lane.hit),      32'h08);
      check("t2_h0_bclk", 32'(lane.ball_clk), 32'd0);
      @(negedge clk);
      check("t2_h1_hit",  32'(lane.hit),      32'h08);
      check("t2_h1_bclk", 32'(lane.ball_clk), 32'd1);
      @(negedge clk);
      check("t2_h2_hit",  32'(lane.hit),      32'h08);
      check("t2_h2_bclk", 32'(lane.ball_clk), 32'd0);
      @(negedge clk);
      check("t2_after_hit", 32'(lane.hit),        32'd0);
      check("t2_balls",     32'(lane.balls_left), 32'd2);
      set_in(7'd0, 1'b0);
      wait_cyc(20);

      // 3: bounce rejected, then simultaneous 100+20 -> 100 only
      for (int i = 0; i < 6; i++) begin
         set_in((i % 2 == 0) ? 7'b0000100 : 7'b0000000, 1'b0);
         wait_cyc(1);
      end
      set_in(7'd0, 1'b0);
      wait_cyc(15);
      @(negedge clk);
      check("t3_bounce_balls", 32'(lane.balls_left), 32'd2);
      set_in(7'b1000100, 1'b0);
      wait_cyc(6);
      @(negedge clk);
      @(negedge clk);
      check("t3_prio_hit", 32'(lane.hit), 32'h40);
      set_in(7'd0, 1'b0);

      // 4: pulse during hold-off is dropped
      pulse(7'b0000010, 6);
      wait_cyc(20);
      @(negedge clk);
      check("t4_holdoff_balls", 32'(lane.balls_left), 32'd1);
      check("t4_holdoff_play",  32'(lane.play_state), 32'd1);
      set_in(7'b0000001, 1'b0);
      wait_cyc(6);
      @(negedge clk);
      @(negedge clk);
      check("t4_gutter_hit", 32'(lane.hit), 32'h01);
      set_in(7'd0, 1'b0);
      wait_cyc(15);
      @(negedge clk);
      check("t4_over",       32'(lane.game_over),  32'd1);
      check("t4_over_play",  32'(lane.play_state), 32'd1);
      check("t4_over_balls", 32'(lane.balls_left), 32'd0);
      press_start();
      @(negedge clk);
      check("t4_idle_play", 32'(lane.play_state), 32'd0);
      check("t4_idle_over", 32'(lane.game_over),  32'd0);
      press_start();
      @(negedge clk);
      check("t4_new_balls", 32'(lane.balls_left), 32'd3);

      // 5: async reset during h1
      set_in(7'b0010000, 1'b0);
      wait_cyc(6);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("t5_h1_bclk", 32'(lane.ball_clk), 32'd1);
      #2;
      rst_n = 1'b0;
      lane.sensor_raw = '0;
      #1;
      check("t5_rst_hit",  32'(lane.hit),        32'd0);
      check("t5_rst_bclk", 32'(lane.ball_clk),   32'd0);
      check("t5_rst_play", 32'(lane.play_state), 32'd0);
      wait_cyc(2);
      #1 rst_n = 1'b1;
      wait_cyc(4);
      @(negedge clk);
      check("t5_idle_play", 32'(lane.play_state), 32'd0);

      // 6: stuck 50-point sensor
      press_start();
      set_in(7'b0100000, 1'b0);
      wait_cyc(60);
      @(negedge clk);
      check("t6_stuck_balls", 32'(lane.balls_left), 32'd2);
`ifdef STUCK_SENSOR_EN
      check("t6_fault_set", 32'(lane.fault), 32'h20);
`else
      check("t6_fault_zero", 32'(lane.fault), 32'h00);
`endif
      set_in(7'd0, 1'b0);
      wait_cyc(15);
      pulse(7'b0100000, 6);
      wait_cyc(20);
      @(negedge clk);
`ifdef STUCK_SENSOR_EN
      check("t6_masked_balls", 32'(lane.balls_left), 32'd2);
`else
      check("t6_unmasked_balls", 32'(lane.balls_left), 32'd1);
`endif
      guard = 0;
      while (lane.game_over !== 1'b1 && guard < 8) begin
         pulse(7'b0000001, 6);
         wait_cyc(20);
         guard++;
      end
      @(negedge clk);
      check("t6_game_over", 32'(lane.game_over), 32'd1);
      press_start();
      press_start();
      @(negedge clk);
      check("t6_fault_clear", 32'(lane.fault),      32'd0);
      check("t6_new_balls",   32'(lane.balls_left), 32'd3);

      // Random stimulus, checked every cycle by the compare process
      for (int it = 0; it < 300; it++) begin
         int       r;
         logic [6:0] pat;
         r = $urandom_range(0, 99);
         if (r < 4) begin
            @(posedge clk);
            #1 rst_n = 1'b0;
            wait_cyc($urandom_range(1, 3));
            #1 rst_n = 1'b1;
         end else if (r < 14) begin
            set_in(7'd0, 1'b1);
            wait_cyc($urandom_range(0, 8));
            set_in(7'd0, 1'b0);
            wait_cyc($urandom_range(0, 6));
         end else begin
            if (r < 60) pat = 7'(1 << $urandom_range(0, 6));
            else        pat = 7'($urandom_range(0, 127));
            set_in(pat, 1'b0);
            wait_cyc($urandom_range(0, 10));
            set_in(7'd0, 1'b0);
            wait_cyc($urandom_range(0, 8));
         end
      end
      wait_cyc(20);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
